dfa_stream_ctx: RTL and testbench

Parametrised per-stream context manager for one regex DFA in the packet-inspection datapath. It saves and restores DFA state per stream ID across packet boundaries and registers all DFA inputs and outputs for timing. It drains the DFA pipeline before committing state at end-of-packet, and keeps saturating match counts. The DFA core is external and connects through the `dfa_*` ports; one instance sits beside each category matcher.

---
 rtl/dfa_stream_ctx.sv | 212 +++++++++++++++++++++
 tb/tb_dfa_stream_ctx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfa_stream_ctx.sv
// Per-stream context manager for one external regex DFA: saves/restores DFA state per stream,
// drains the DFA pipeline before commit, keeps saturating match counts. Optional per-stream
// counter array is built when DFA_CTX_PER_STREAM_COUNT_EN is defined.
module dfa_stream_ctx #(
  parameter int unsigned STATE_W     = 11,
  parameter int unsigned STREAMS     = 64,
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned RESET_STATE = 0,
  localparam int unsigned SID_W      = $clog2(STREAMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_state,
  input  logic               new_stream_id,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  input  logic               clr_count,
  output logic [7:0]         dfa_char,
  output logic               dfa_char_vld,
  output logic [STATE_W-1:0] dfa_state_in,
  output logic               dfa_state_in_vld,
  input  logic [STATE_W-1:0] dfa_state_out,
  input  logic               dfa_accept,
  output logic               fired,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               proto_err,
  input  logic [SID_W-1:0]   cnt_rd_sid,
  output logic [COUNT_W-1:0] cnt_rd_data,
  output logic [2:0]         dbg_state
);

  // Handshake: there is no back-pressure. load_state is honoured only in IDLE, eop only in RUN,
  // char_in_vld only in RUN; anything else is dropped (the first two raise proto_err).

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DRAIN2 = 3'd4,
    S_COMMIT = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic load_go, in_load, in_run, in_commit, in_window, proto_err_d;

  logic [SID_W-1:0]   sid_q, sid_d;
  logic               new_q, new_d;
  logic               en_q, en_d;
  logic               fired_q, fired_d, fired_now;
  logic [STREAMS-1:0] valid_q, valid_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               proto_err_q;
  logic [7:0]         dfa_char_q, dfa_char_d;
  logic               dfa_char_vld_q, dfa_char_vld_d;
  logic [STATE_W-1:0] dfa_state_in_q, dfa_state_in_d;
  logic               dfa_state_in_vld_q, dfa_state_in_vld_d;
  logic [STATE_W-1:0] dfa_out_state_q;
  logic               dfa_out_accept_q;
  logic               commit_en, commit_inc;

  logic [STATE_W-1:0] state_mem_q [STREAMS];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (load_state) state_d = S_LOAD;
      S_LOAD:   state_d = S_RUN;
      S_RUN:    if (eop) state_d = S_DRAIN1;
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs / decodes
  always_comb begin
    busy        = (state_q != S_IDLE);
    load_go     = (state_q == S_IDLE) && load_state;
    in_load     = (state_q == S_LOAD);
    in_run      = (state_q == S_RUN);
    in_commit   = (state_q == S_COMMIT);
    in_window   = (state_q == S_RUN) || (state_q == S_DRAIN1) ||
                  (state_q == S_DRAIN2) || (state_q == S_COMMIT);
    proto_err_d = (load_state && (state_q != S_IDLE)) || (eop && (state_q != S_RUN));
  end

  // Datapath next-state
  always_comb begin
    sid_d = load_go ? stream_id : sid_q;
    new_d = load_go ? new_stream_id : new_q;
    en_d  = (in_run && eop) ? enable : en_q;

    // The COMMIT cycle's accept belongs to the last byte, so it counts toward this packet.
    fired_now = fired_q | (in_window & dfa_out_accept_q);
    commit_en = in_commit & en_q;
    commit_inc = commit_en & fired_now;

    if (load_go)                 fired_d = 1'b0;
    else if (in_commit && !en_q) fired_d = 1'b0;
    else                         fired_d = fired_now;

    dfa_state_in_d     = dfa_state_in_q;
    dfa_state_in_vld_d = in_load;
    if (in_load) begin
      if (new_q || !valid_q[sid_q]) dfa_state_in_d = STATE_W'(RESET_STATE);
      else                          dfa_state_in_d = state_mem_q[sid_q];
    end

    dfa_char_vld_d = in_run & char_in_vld;
    dfa_char_d     = dfa_char_vld_d ? char_in : dfa_char_q;

    valid_d = valid_q;
    if (commit_en) valid_d[sid_q] = 1'b1;

    count_d = count_q;
    if (clr_count)                           count_d = '0;
    else if (commit_inc && (count_q != '1))  count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sid_q              <= '0;
      new_q              <= 1'b0;
      en_q               <= 1'b0;
      fired_q            <= 1'b0;
      valid_q            <= '0;
      count_q            <= '0;
      proto_err_q        <= 1'b0;
      dfa_char_q         <= '0;
      dfa_char_vld_q     <= 1'b0;
      dfa_state_in_q     <= '0;
      dfa_state_in_vld_q <= 1'b0;
      dfa_out_state_q    <= '0;
      dfa_out_accept_q   <= 1'b0;
    end else begin
      sid_q              <= sid_d;
      new_q              <= new_d;
      en_q               <= en_d;
      fired_q            <= fired_d;
      valid_q            <= valid_d;
      count_q            <= count_d;
      proto_err_q        <= proto_err_d;
      dfa_char_q         <= dfa_char_d;
      dfa_char_vld_q     <= dfa_char_vld_d;
      dfa_state_in_q     <= dfa_state_in_d;
      dfa_state_in_vld_q <= dfa_state_in_vld_d;
      dfa_out_state_q    <= dfa_state_out;
      dfa_out_accept_q   <= dfa_accept;
    end
  end

  // Context memory carries no reset; the valid bits guard reads of unwritten entries.
  always_ff @(posedge clk) begin
    if (commit_en) state_mem_q[sid_q] <= dfa_out_state_q;
  end

`ifdef DFA_CTX_PER_STREAM_COUNT_EN
  logic [COUNT_W-1:0] pcnt_q [STREAMS];
  logic [COUNT_W-1:0] pcnt_d [STREAMS];
  logic [COUNT_W-1:0] rd_q, rd_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_count) begin
      for (int i = 0; i < int'(STREAMS); i++) pcnt_d[i] = '0;
    end else if (commit_inc && (pcnt_q[sid_q] != '1)) begin
      pcnt_d[sid_q] = pcnt_q[sid_q] + COUNT_W'(1);
    end
    rd_d = pcnt_q[cnt_rd_sid];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STREAMS); i++) pcnt_q[i] <= '0;
      rd_q <= '0;
    end else begin
      for (int i = 0; i < int'(STREAMS); i++) pcnt_q[i] <= pcnt_d[i];
      rd_q <= rd_d;
    end
  end

  assign cnt_rd_data = rd_q;
`else
  logic unused_rd_sid;
  assign unused_rd_sid = ^cnt_rd_sid;
  assign cnt_rd_data   = '0;
`endif

  assign dfa_char         = dfa_char_q;
  assign dfa_char_vld     = dfa_char_vld_q;
  assign dfa_state_in     = dfa_state_in_q;
  assign dfa_state_in_vld = dfa_state_in_vld_q;
  assign fired            = fired_now;
  assign count            = count_q;
  assign proto_err        = proto_err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_dfa_stream_ctx.sv
// Bench for dfa_stream_ctx: a stub DFA recognising "ab" drives the dfa_* return path, and a
// packet-level reference model predicts start states, fired, and counts.
module tb_dfa_stream_ctx;
  localparam int SW = 11;
  localparam int NS = 64;
  localparam int CW = 8;
  localparam int SIDW = $clog2(NS);
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_state = 1'b0, new_stream_id = 1'b0, enable = 1'b0;
  logic [SIDW-1:0] stream_id = '0, cnt_rd_sid = '0;
  logic [7:0]      char_in = '0;
  logic            char_in_vld = 1'b0, eop = 1'b0, clr_count = 1'b0;
  logic [7:0]      dfa_char;
  logic            dfa_char_vld, dfa_state_in_vld, dfa_accept, fired, busy, proto_err;
  logic [SW-1:0]   dfa_state_in, dfa_state_out;
  logic [CW-1:0]   count, cnt_rd_data;
  logic [2:0]      dbg_state;

  int total = 0;
  int bad = 0;

  dfa_stream_ctx #(.STATE_W(SW), .STREAMS(NS), .COUNT_W(CW), .RESET_STATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .load_state(load_state), .new_stream_id(new_stream_id),
    .stream_id(stream_id), .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld),
    .eop(eop), .clr_count(clr_count), .dfa_char(dfa_char), .dfa_char_vld(dfa_char_vld),
    .dfa_state_in(dfa_state_in), .dfa_state_in_vld(dfa_state_in_vld),
    .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept), .fired(fired), .count(count),
    .busy(busy), .proto_err(proto_err), .cnt_rd_sid(cnt_rd_sid), .cnt_rd_data(cnt_rd_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // DFA transition: low 2 bits track progress through "ab", upper bits count bytes seen.
  function automatic logic [SW-1:0] dfa_step(input logic [SW-1:0] s, input logic [7:0] c);
    logic [SW-3:0] up;
    logic [1:0]    p;
    up = s[SW-1:2] + 1'b1;
    if (c == 8'h61)                        p = 2'd1;
    else if (s[1:0] == 2'd1 && c == 8'h62) p = 2'd2;
    else                                   p = 2'd0;
    return {up, p};
  endfunction

  // stub DFA core, one-cycle latency
  logic [SW-1:0] stub_st;
  logic          stub_acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_st  <= '0;
      stub_acc <= 1'b0;
    end else if (dfa_char_vld) begin
      stub_st  <= dfa_step(stub_st, dfa_char);
      stub_acc <= (dfa_step(stub_st, dfa_char) & 11'h3) == 11'd2;
    end else begin
      stub_acc <= 1'b0;
      if (dfa_state_in_vld) stub_st <= dfa_state_in;
    end
  end
  assign dfa_state_out = stub_st;
  assign dfa_accept    = stub_acc;

  // reference model / scoreboard
  logic [SW-1:0] m_mem [NS];
  bit            m_valid [NS];
  int            m_count;
  int            m_pcnt [NS];
  logic [SW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_pcnt[i]  = 0;
    end
    m_count = 0;
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 3))
      0: return 8'h61;
      1: return 8'h62;
      2: return 8'h78;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // drive one packet from load_state through commit and check against the model
  task automatic run_pkt(input int sid, input bit nw, input bit en, input int nbytes,
                         input bit force_match, input bit eop_sep, input bit inj_load,
                         input bit clr_at_commit);
    logic [7:0]    bytes [$];
    logic [SW-1:0] start, s;
    bit            exp_fired;
    start = (nw || !m_valid[sid]) ? '0 : m_mem[sid];
    exp_q.push_back(start);
    for (int i = 0; i < nbytes; i++) begin
      if (force_match && i == nbytes - 2)      bytes.push_back(8'h61);
      else if (force_match && i == nbytes - 1) bytes.push_back(8'h62);
      else                                     bytes.push_back(pick_byte());
    end
    s = start;
    exp_fired = 1'b0;
    foreach (bytes[i]) begin
      s = dfa_step(s, bytes[i]);
      if (s[1:0] == 2'd2) exp_fired = 1'b1;
    end

    @(negedge clk);
    load_state = 1'b1; stream_id = SIDW'(sid); new_stream_id = nw; enable = ~en;
    @(negedge clk);
    load_state = 1'b0; new_stream_id = ~nw;
    @(negedge clk);
    check("state_in_vld", 32'(dfa_state_in_vld), 32'd1);
    check("state_in", 32'(dfa_state_in), 32'(exp_q.pop_front()));
    check("fired_clr_at_load", 32'(fired), 32'd0);

    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        char_in = 8'($urandom_range(0, 255)); char_in_vld = 1'b0;
        @(negedge clk);
        check("char_gap_vld", 32'(dfa_char_vld), 32'd0);
      end
      char_in = bytes[i]; char_in_vld = 1'b1;
      eop = (i == nbytes - 1) && !eop_sep;
      if (i == nbytes - 1) enable = en;
      if (inj_load && i == 0) load_state = 1'b1;
      @(negedge clk);
      check("dfa_char", 32'(dfa_char), 32'(bytes[i]));
      check("dfa_char_vld", 32'(dfa_char_vld), 32'd1);
      if (inj_load && i == 0) begin
        check("perr_load_in_run", 32'(proto_err), 32'd1);
        check("state_after_perr", 32'(busy), 32'd1);
        load_state = 1'b0;
      end
    end
    char_in_vld = 1'b0;
    if (eop_sep) begin
      eop = 1'b1;
      @(negedge clk);
    end
    eop = 1'b0; enable = ~en;
    @(negedge clk);
    @(negedge clk);
    check("fired_at_commit", 32'(fired), 32'(exp_fired));
    check("busy_at_commit", 32'(busy), 32'd1);
    if (clr_at_commit) clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    if (en) begin
      m_mem[sid]   = s;
      m_valid[sid] = 1'b1;
      if (exp_fired) begin
        if (m_count < CMAX)      m_count++;
        if (m_pcnt[sid] < CMAX)  m_pcnt[sid]++;
      end
    end
    if (clr_at_commit) begin
      m_count = 0;
      for (int i = 0; i < NS; i++) m_pcnt[i] = 0;
    end
    check("busy_after_commit", 32'(busy), 32'd0);
    check("count", 32'(count), 32'(m_count));
    check("fired_after_commit", 32'(fired), en ? 32'(exp_fired) : 32'd0);
  endtask

  task automatic eop_idle();
    @(negedge clk);
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    check("perr_eop_idle", 32'(proto_err), 32'd1);
    check("busy_eop_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("perr_one_pulse", 32'(proto_err), 32'd0);
    check("count_eop_idle", 32'(count), 32'(m_count));
  endtask

  task automatic read_pcnt(input int sid);
    @(negedge clk);
    cnt_rd_sid = SIDW'(sid);
    @(negedge clk);
`ifdef DFA_CTX_PER_STREAM_COUNT_EN
    check("pcnt_rd", 32'(cnt_rd_data), 32'(m_pcnt[sid]));
`else
    check("pcnt_rd_tied0", 32'(cnt_rd_data), 32'd0);
`endif
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_fired", 32'(fired), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    check("rst_dfa_char", 32'({dfa_char, dfa_char_vld}), 32'd0);
    check("rst_dfa_state_in", 32'({dfa_state_in, dfa_state_in_vld}), 32'd0);
    check("rst_fsm", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // directed: enable=0 leaves stream 3 invalid, then enabled match, then saved-state restore
    run_pkt(3, 1, 0, 4, 1, 0, 0, 0);
    run_pkt(3, 0, 1, 4, 1, 0, 0, 0);
    run_pkt(3, 0, 1, 3, 0, 1, 0, 0);
    run_pkt(5, 0, 1, 2, 0, 0, 0, 0);
    eop_idle();
    run_pkt(6, 1, 1, 3, 1, 0, 1, 0);

    // per-stream counts from a clean slate
    run_pkt(0, 1, 1, 2, 0, 0, 0, 1);
    run_pkt(7, 1, 1, 3, 1, 0, 0, 0);
    run_pkt(7, 0, 1, 2, 1, 1, 0, 0);
    run_pkt(2, 1, 1, 5, 1, 0, 0, 0);
    read_pcnt(7);
    read_pcnt(2);
    read_pcnt(3);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      run_pkt($urandom_range(0, 7), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
              $urandom_range(1, 6), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0));
      if (n % 25 == 0) read_pcnt($urandom_range(0, 7));
    end

    // clear coinciding with a matching commit
    run_pkt(4, 1, 1, 2, 1, 0, 0, 1);

    // drive the counter into saturation
    for (int n = 0; n < CMAX + 5; n++) run_pkt(1, 0, 1, 2, 1, 0, 0, 0);
    check("count_saturated", 32'(count), 32'(CMAX));
    read_pcnt(1);

    // reset mid-packet: no commit, everything back to initial
    @(negedge clk);
    load_state = 1'b1; stream_id = SIDW'(3); new_stream_id = 1'b0; enable = 1'b1;
    @(negedge clk);
    load_state = 1'b0;
    @(negedge clk);
    char_in = 8'h61; char_in_vld = 1'b1;
    @(negedge clk);
    char_in = 8'h62; eop = 1'b1;
    @(negedge clk);
    char_in_vld = 1'b0; eop = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_pkt(3, 0, 1, 3, 0, 0, 0, 0);
    read_pcnt(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
